// File: rtl/icache_controller.sv
// -----------------------------------------------------------------------------
// icache_controller
//   Direct-mapped instruction cache sitting between the fetch stage and a
//   128-bit-block instruction memory. A hit returns the 32-bit word in the same
//   cycle. A miss stalls fetch, reads the whole block from memory and fills the
//   line. After that, the lookup is repeated in IDLE.
//
// Ports
//   CLOCK          in   1    clock, all state updates on posedge
//   RESET          in   1    asynchronous active-low reset
//   PC_ADDRESS     in   32   byte address to fetch ([1:0] ignored)
//   FLUSH          in   1    single-cycle pulse, invalidate every line
//   INSTRUCTION    out  32   fetched word, NOP_INSTR while stalled
//   CPU_BUSYWAIT   out  1    stall request to the fetch stage
//   MEM_READ       out  1    block read request
//   MEM_ADDRESS    out  28   latched block address (PC[31:4] of the miss)
//   MEM_READDATA   in   128  block from memory, byte 0 in [7:0]
//   MEM_BUSYWAIT   in   1    memory busy (rises after READ seen)
//   MISS_COUNT     out  16   completed line fills, saturating
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | lookup on PC_ADDRESS; a hit is served, a miss latches the block
// S_MEM_READ | READ held high; wait for memory busy to fall
// S_UPDATE   | write captured block + tag into the line, count the fill
// -----------------------------------------------------------------------------
module icache_controller #(
    parameter int          INDEX_BITS = 3,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic [31:0]  PC_ADDRESS,
    input  logic         FLUSH,
    output logic [31:0]  INSTRUCTION,
    output logic         CPU_BUSYWAIT,
    output logic         MEM_READ,
    output logic [27:0]  MEM_ADDRESS,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT,
    output logic [15:0]  MISS_COUNT
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_READ = 2'd1,
        S_UPDATE   = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [27:0]                     addr_q, addr_d;
    logic                            first_q, first_d;
    logic                            drop_q, drop_d;
    logic [127:0]                    block_q, block_d;
    logic [15:0]                     miss_count_q, miss_count_d;
    logic [LINES-1:0]                valid_q, valid_d;
    logic [LINES-1:0][TAG_W-1:0]     tag_q, tag_d;
    logic [LINES-1:0][127:0]         data_q, data_d;

    logic [1:0]                      pc_word;
    logic [INDEX_BITS-1:0]           pc_index;
    logic [TAG_W-1:0]                pc_tag;
    logic [INDEX_BITS-1:0]           fill_index;
    logic [TAG_W-1:0]                fill_tag;
    logic                            hit;
    logic                            unused_pc_bits;

    assign pc_word        = PC_ADDRESS[3:2];
    assign pc_index       = PC_ADDRESS[3+INDEX_BITS:4];
    assign pc_tag         = PC_ADDRESS[31:4+INDEX_BITS];
    assign fill_index     = addr_q[INDEX_BITS-1:0];
    assign fill_tag       = addr_q[27:INDEX_BITS];
    assign unused_pc_bits = ^PC_ADDRESS[1:0];

    assign hit          = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
    assign CPU_BUSYWAIT = !((state_q == S_IDLE) && hit);
    assign INSTRUCTION  = CPU_BUSYWAIT ? NOP_INSTR
                                       : data_q[pc_index][{pc_word, 5'b00000} +: 32];
    assign MEM_READ     = (state_q == S_MEM_READ);
    assign MEM_ADDRESS  = addr_q;
    assign MISS_COUNT   = miss_count_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        first_d      = first_q;
        drop_d       = drop_q;
        block_d      = block_q;
        miss_count_d = miss_count_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;

        case (state_q)
            S_IDLE: begin
                if (!hit) begin
                    state_d = S_MEM_READ;
                    addr_d  = PC_ADDRESS[31:4];
                    first_d = 1'b1;
                end
            end
            S_MEM_READ: begin
                // Memory raises busy only after it has seen READ, so a low
                // busy in the first request cycle is not a completion.
                if (first_q) begin
                    first_d = 1'b0;
                end else if (!MEM_BUSYWAIT) begin
                    block_d = MEM_READDATA;
                    state_d = S_UPDATE;
                end
                // A fence.i during the fill must not let stale data become valid.
                if (FLUSH) begin
                    drop_d = 1'b1;
                end
            end
            S_UPDATE: begin
                data_d[fill_index]  = block_q;
                tag_d[fill_index]   = fill_tag;
                valid_d[fill_index] = !drop_q;
                if (miss_count_q != 16'hFFFF) begin
                    miss_count_d = miss_count_q + 16'd1;
                end
                drop_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Applied last so a flush coinciding with UPDATE leaves the line invalid.
        if (FLUSH) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            first_q      <= 1'b0;
            drop_q       <= 1'b0;
            block_q      <= '0;
            miss_count_q <= '0;
            valid_q      <= '0;
            tag_q        <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            first_q      <= first_d;
            drop_q       <= drop_d;
            block_q      <= block_d;
            miss_count_q <= miss_count_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
        end
    end

endmodule

// File: tb/tb_icache_controller.sv
// -----------------------------------------------------------------------------
// tb_icache_controller
//   Directed bench for icache_controller. A memory responder answers block
//   reads with a fixed busy length. A reference model follows the cache
//   contents and the progress of any fill at block level, and the outputs are
//   compared against it on every negedge. The directed sequence adds literal
//   expectations for stall length, data words and fill count.
// -----------------------------------------------------------------------------
module tb_icache_controller;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic         CLOCK = 1'b0;
    logic         RESET;
    logic [31:0]  PC_ADDRESS;
    logic         FLUSH;
    logic [31:0]  INSTRUCTION;
    logic         CPU_BUSYWAIT;
    logic         MEM_READ;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
    logic [15:0]  MISS_COUNT;

    int errors = 0;
    int checks = 0;

    icache_controller #(.INDEX_BITS(3), .NOP_INSTR(NOP)) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .PC_ADDRESS  (PC_ADDRESS),
        .FLUSH       (FLUSH),
        .INSTRUCTION (INSTRUCTION),
        .CPU_BUSYWAIT(CPU_BUSYWAIT),
        .MEM_READ    (MEM_READ),
        .MEM_ADDRESS (MEM_ADDRESS),
        .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT),
        .MISS_COUNT  (MISS_COUNT)
    );

    always #5 CLOCK = ~CLOCK;

    // Memory image: each word is its own byte address xor a constant.
    function automatic logic [31:0] mem_word(input logic [31:0] byte_addr);
        return {byte_addr[31:2], 2'b00} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [127:0] mem_block(input logic [27:0] blk);
        logic [127:0] b;
        for (int k = 0; k < 4; k++) begin
            b[32*k +: 32] = mem_word({blk, k[1:0], 2'b00});
        end
        return b;
    endfunction

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------ memory side
    int  mem_lat  = 5;
    bit  slow_ack = 0;
    bit  m_active = 0;
    bit  m_delay  = 0;
    int  m_cnt    = 0;

    initial begin
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = '0;
        forever begin
            @(posedge CLOCK);
            #1;
            if (!RESET) begin
                m_active = 0; m_delay = 0; m_cnt = 0; MEM_BUSYWAIT = 1'b0;
            end else if (MEM_READ) begin
                if (!m_active) begin
                    m_active     = 1;
                    m_cnt        = mem_lat;
                    m_delay      = slow_ack;
                    MEM_BUSYWAIT = !slow_ack;
                    MEM_READDATA = {4{32'hDEAD_BEEF}};
                end else if (m_delay) begin
                    m_delay      = 0;
                    MEM_BUSYWAIT = 1'b1;
                end else if (m_cnt > 1) begin
                    m_cnt--;
                end else if (m_cnt == 1) begin
                    m_cnt        = 0;
                    MEM_BUSYWAIT = 1'b0;
                    MEM_READDATA = mem_block(MEM_ADDRESS);
                end
            end else begin
                m_active = 0; MEM_BUSYWAIT = 1'b0;
            end
        end
    end

    // ------------------------------------------------------- reference model
    // fill phase: 0 none, 1 first request cycle, 2 waiting on memory, 3 write-back
    int          f_phase;
    logic [27:0] f_blk;
    bit          f_drop;
    bit   [7:0]  line_valid;
    logic [27:0] line_blk [8];
    int          fills;

    always @(negedge CLOCK) begin : compare
        bit          e_hit;
        int          idx;
        if (!RESET) begin
            f_phase = 0; f_blk = '0; f_drop = 0; line_valid = '0; fills = 0;
            e_hit = 0;
        end else begin
            idx   = int'(PC_ADDRESS[6:4]);
            e_hit = (f_phase == 0) && line_valid[idx] && (line_blk[idx] == PC_ADDRESS[31:4]);
        end
        check("cpu_busywait", {31'b0, CPU_BUSYWAIT}, {31'b0, !e_hit});
        check("instruction", INSTRUCTION, e_hit ? mem_word(PC_ADDRESS) : NOP);
        check("mem_read", {31'b0, MEM_READ}, {31'b0, (f_phase == 1 || f_phase == 2)});
        check("mem_address", {4'b0, MEM_ADDRESS}, {4'b0, f_blk});
        check("miss_count", {16'b0, MISS_COUNT}, fills);

        if (RESET) begin
            case (f_phase)
                0: if (!e_hit) begin f_phase = 1; f_blk = PC_ADDRESS[31:4]; end
                1: f_phase = 2;
                2: if (!MEM_BUSYWAIT) f_phase = 3;
                default: begin
                    line_blk[int'(f_blk[2:0])]   = f_blk;
                    line_valid[int'(f_blk[2:0])] = !f_drop;
                    if (fills < 65535) fills++;
                    f_drop  = 0;
                    f_phase = 0;
                end
            endcase
            if (FLUSH) begin
                line_valid = '0;
                if (f_phase == 1 || f_phase == 2 || f_phase == 3) begin
                    // phase was advanced above: 1/2/3 here means a fill was in flight
                    // unless the write-back just completed
                end
            end
        end
    end

    // Drop flag is set by the model from the pre-edge phase.
    always @(negedge CLOCK) begin : drop_track
        if (RESET && FLUSH && (f_phase == 1 || f_phase == 2)) begin
            f_drop = 1;
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge CLOCK);
        #2;
    endtask

    task automatic fetch(input logic [31:0] pc, input int flush_cyc,
                         output int stalls, output logic [31:0] instr);
        bit done;
        done       = 0;
        stalls     = 0;
        instr      = '0;
        PC_ADDRESS = pc;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge CLOCK);
            if (!CPU_BUSYWAIT) begin
                done  = 1;
                instr = INSTRUCTION;
            end else begin
                stalls++;
            end
            tick();
            FLUSH = (c + 1 == flush_cyc);
        end
        FLUSH = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: pc %h still stalled after 100 cycles", pc);
        end
    endtask

    int          st;
    logic [31:0] ins;

    initial begin
        RESET      = 1'b0;
        PC_ADDRESS = 32'h0;
        FLUSH      = 1'b0;
        repeat (3) @(negedge CLOCK);
        check("reset_busywait", {31'b0, CPU_BUSYWAIT}, 32'd1);
        check("reset_mem_read", {31'b0, MEM_READ}, 32'd0);
        check("reset_miss_count", {16'b0, MISS_COUNT}, 32'd0);
        tick();
        RESET = 1'b1;

        // cold miss on block 0
        fetch(32'h0, 0, st, ins);
        check("t1_stalls", st, 32'd8);
        check("t1_word0", ins, 32'h5A5A_0000);

        // hits on the rest of block 0
        fetch(32'h4, 0, st, ins);
        check("t2_stalls_w1", st, 32'd0);
        check("t2_word1", ins, 32'h5A5A_0004);
        fetch(32'h8, 0, st, ins);
        check("t2_word2", ins, 32'h5A5A_0008);
        fetch(32'hC, 0, st, ins);
        check("t2_word3", ins, 32'h5A5A_000C);
        check("t2_miss_count", {16'b0, MISS_COUNT}, 32'd1);

        // conflict on index 0
        fetch(32'h80, 0, st, ins);
        check("t3_stalls_80", st, 32'd8);
        check("t3_word_80", ins, 32'h5A5A_0080);
        fetch(32'h0, 0, st, ins);
        check("t3_stalls_0", st, 32'd8);
        check("t3_miss_count", {16'b0, MISS_COUNT}, 32'd3);

        // flush during MEM_READ: fill is dropped, line refetched
        fetch(32'h10, 3, st, ins);
        check("t4_stalls", st, 32'd16);
        check("t4_word", ins, 32'h5A5A_0010);
        check("t4_miss_count", {16'b0, MISS_COUNT}, 32'd5);

        // flush in the UPDATE cycle also leaves the line invalid
        fetch(32'h34, 7, st, ins);
        check("t4b_stalls", st, 32'd16);
        check("t4b_word", ins, 32'h5A5A_0034);
        check("t4b_miss_count", {16'b0, MISS_COUNT}, 32'd7);

        // reset in the middle of a fill
        PC_ADDRESS = 32'h20;
        tick(); tick(); tick();
        check("t5_mem_read_before", {31'b0, MEM_READ}, 32'd1);
        RESET = 1'b0;
        #1;
        check("t5_mem_read_async", {31'b0, MEM_READ}, 32'd0);
        check("t5_busywait_async", {31'b0, CPU_BUSYWAIT}, 32'd1);
        tick(); tick();
        PC_ADDRESS = 32'h10;
        tick();
        RESET = 1'b1;
        fetch(32'h10, 0, st, ins);
        check("t5_stalls_after_reset", st, 32'd8);
        check("t5_miss_count", {16'b0, MISS_COUNT}, 32'd1);
        fetch(32'h14, 0, st, ins);
        check("t5_hit_word", ins, 32'h5A5A_0014);

        // memory raises busy one cycle late
        slow_ack = 1;
        fetch(32'h40, 0, st, ins);
        slow_ack = 0;
        check("t6_stalls", st, 32'd9);
        check("t6_word", ins, 32'h5A5A_0040);
        check("t6_miss_count", {16'b0, MISS_COUNT}, 32'd2);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
